// File: rtl/relu_pool_writeback.sv
// Requantizes, optionally ReLUs and 2x2 max-pools the PE array's psum stream, then
// packs the int8 results four per word and writes them to the OARG BRAM port.
module relu_pool_writeback #(
  parameter int PSUM_DATA_SIZE   = 32,
  parameter int DATA_BITWIDTH    = 32,
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int FIXPOINT_LEN     = 8,
  parameter int OUT_DATA_SIZE    = 8,
  parameter int MAX_WIDTH        = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  cfg_width,
  input  logic [7:0]                  cfg_height,
  input  logic                        cfg_relu,
  input  logic                        cfg_pool,
  input  logic [ADDRESS_BITWIDTH-1:0] base_address,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PSUM_DATA_SIZE-1:0]   in_data,
  output logic [ADDRESS_BITWIDTH-1:0] OARG_address,
  output logic [DATA_BITWIDTH-1:0]    OARG_wdata,
  output logic                        OARG_e,
  output logic [3:0]                  OARG_we,
  output logic                        busy,
  output logic                        done
);

  localparam int BYTES_PER_WORD = DATA_BITWIDTH / OUT_DATA_SIZE;
  localparam int BC_W           = $clog2(BYTES_PER_WORD);
  localparam int LB_DEPTH       = MAX_WIDTH / 2;
  localparam int LB_AW          = $clog2(LB_DEPTH);
  localparam logic signed [PSUM_DATA_SIZE-1:0] Q_MAX = PSUM_DATA_SIZE'(2**(OUT_DATA_SIZE-1) - 1);
  localparam logic signed [PSUM_DATA_SIZE-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_next;

  logic [7:0]                  cfg_width_r, cfg_height_r;
  logic                        cfg_relu_r, cfg_pool_r;
  logic [7:0]                  col, row;
  logic                        start_frame, fire, last_psum;

  logic                        s1_valid, s1_row_odd;
  logic [7:0]                  s1_col;
  logic signed [OUT_DATA_SIZE-1:0] s1_q;

  logic signed [PSUM_DATA_SIZE-1:0] q_shift, q_relu;
  logic signed [OUT_DATA_SIZE-1:0]  q_sat, held, h, lb_rd, pool_out, out_byte;
  logic signed [OUT_DATA_SIZE-1:0]  linebuf [LB_DEPTH];
  logic [LB_AW-1:0]                 lb_idx;
  logic                             out_valid, flush_partial;

  logic [DATA_BITWIDTH-1:0]    pack_reg, pack_next;
  logic [BC_W-1:0]             byte_cnt;
  logic [ADDRESS_BITWIDTH-1:0] wr_addr;

  assign start_frame = (state == IDLE) && start;
  assign fire        = in_valid && in_ready;
  assign last_psum   = (row == cfg_height_r - 8'd1) && (col == cfg_width_r - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal assigned here gets a default first so no latch can be inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE:  if (start) state_next = (cfg_width != 8'd0 && cfg_height != 8'd0) ? RUN : DONE;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (fire && last_psum) state_next = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        // Partial word goes out first; leave only once nothing is pending.
        if (!s1_valid && byte_cnt == '0) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_width_r  <= '0;
      cfg_height_r <= '0;
      cfg_relu_r   <= 1'b0;
      cfg_pool_r   <= 1'b0;
      col          <= '0;
      row          <= '0;
    end else if (start_frame) begin
      cfg_width_r  <= cfg_width;
      cfg_height_r <= cfg_height;
      cfg_relu_r   <= cfg_relu;
      cfg_pool_r   <= cfg_pool;
      col          <= '0;
      row          <= '0;
    end else if (fire) begin
      if (col == cfg_width_r - 8'd1) begin
        col <= '0;
        row <= row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  always_comb begin
    q_shift = $signed(in_data) >>> FIXPOINT_LEN;
    q_relu  = (cfg_relu_r && q_shift[PSUM_DATA_SIZE-1]) ? '0 : q_shift;
    if (q_relu > Q_MAX)      q_sat = OUT_DATA_SIZE'(Q_MAX);
    else if (q_relu < Q_MIN) q_sat = OUT_DATA_SIZE'(Q_MIN);
    else                     q_sat = q_relu[OUT_DATA_SIZE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      s1_col     <= '0;
      s1_row_odd <= 1'b0;
    end else begin
      s1_valid <= fire;
      if (fire) begin
        s1_q       <= q_sat;
        s1_col     <= col;
        s1_row_odd <= row[0];
      end
    end
  end

  // Odd trailing columns/rows never reach an odd/odd position, so they drop out naturally.
  always_comb begin
    lb_idx        = s1_col[LB_AW:1];
    lb_rd         = linebuf[lb_idx];
    h             = (s1_q > held) ? s1_q : held;
    pool_out      = (lb_rd > h) ? lb_rd : h;
    out_valid     = s1_valid && (!cfg_pool_r || (s1_col[0] && s1_row_odd));
    out_byte      = cfg_pool_r ? pool_out : s1_q;
    pack_next     = pack_reg | (DATA_BITWIDTH'($unsigned(out_byte)) << (OUT_DATA_SIZE * byte_cnt));
    flush_partial = (state == FLUSH) && !s1_valid && (byte_cnt != '0);
  end

  // NOTE: the line buffer has no reset; each entry is written on an even row before any read.
  always_ff @(posedge clk) begin
    if (s1_valid && cfg_pool_r && s1_col[0] && !s1_row_odd) linebuf[lb_idx] <= h;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held         <= '0;
      pack_reg     <= '0;
      byte_cnt     <= '0;
      wr_addr      <= '0;
      OARG_address <= '0;
      OARG_wdata   <= '0;
      OARG_e       <= 1'b0;
      OARG_we      <= '0;
    end else begin
      OARG_e  <= 1'b0;
      OARG_we <= '0;
      if (s1_valid && cfg_pool_r && !s1_col[0]) held <= s1_q;
      if (start_frame) begin
        pack_reg <= '0;
        byte_cnt <= '0;
        wr_addr  <= base_address;
      end else if (out_valid) begin
        if (byte_cnt == BC_W'(BYTES_PER_WORD - 1)) begin
          OARG_e       <= 1'b1;
          OARG_we      <= 4'b1111;
          OARG_wdata   <= pack_next;
          OARG_address <= wr_addr;
          wr_addr      <= wr_addr + ADDRESS_BITWIDTH'(DATA_BITWIDTH / 8);
          pack_reg     <= '0;
          byte_cnt     <= '0;
        end else begin
          pack_reg <= pack_next;
          byte_cnt <= byte_cnt + BC_W'(1);
        end
      end else if (flush_partial) begin
        OARG_e       <= 1'b1;
        OARG_we      <= 4'((1 << byte_cnt) - 1);
        OARG_wdata   <= pack_reg;
        OARG_address <= wr_addr;
        wr_addr      <= wr_addr + ADDRESS_BITWIDTH'(DATA_BITWIDTH / 8);
        pack_reg     <= '0;
        byte_cnt     <= '0;
      end
    end
  end

endmodule
